music_sequencer: RTL and testbench

- Playback controller for the background-music note ROM: 256 x 8-bit entries, synchronous read with 1-cycle latency.
- Walks a programmable address window at a fixed step rate (one ROM entry = one 1/16-note step).
- Handles play/pause/stop and looping, and presents a stable 6-bit note code plus gate to the downstream tone generator.

---
 rtl/music_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_music_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/music_sequencer.sv
// music_sequencer: playback controller for the background-music note ROM.
// Walks a latched address window at a fixed step rate, with play/pause/stop
// and looping, and drives a registered note code plus gate.
// Optional articulation gap: define MUSIC_ARTIC_EN to force the gate low for
// the last ARTIC_GAP cycles of each HOLD.
module music_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int DIV_W     = 24,
    parameter int ARTIC_GAP = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              play,
    input  logic              pause,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [ADDR_W-1:0] loop_start,
    input  logic [ADDR_W-1:0] loop_end,
    input  logic [DIV_W-1:0]  step_div,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_note,
    output logic [5:0]        note_out,
    output logic              note_on,
    output logic              step_strobe,
    output logic              playing,
    output logic              paused,
    output logic              done
);

`ifdef MUSIC_ARTIC_EN
    localparam logic ARTIC_EN = 1'b1;
`else
    localparam logic ARTIC_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_LATCH, S_HOLD, S_PAUSED, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        note_q, note_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] start_lat_q, start_lat_d;
    logic [ADDR_W-1:0] end_lat_q, end_lat_d;
    logic [DIV_W-1:0]  div_lat_q, div_lat_d;
    logic              strobe_q, strobe_d;
    logic              note_on_q, note_on_d;
    logic              playing_q, playing_d;
    logic              paused_q, paused_d;
    logic              done_q, done_d;
    logic [DIV_W-1:0]  div_eff;
    logic              unused_rom_bits;

    // The two top ROM bits carry no meaning for playback.
    assign unused_rom_bits = ^rom_note[7:6];

    // Step-rate clamp, next-state, datapath and registered-output decode.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        note_d      = note_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        start_lat_d = start_lat_q;
        end_lat_d   = end_lat_q;
        div_lat_d   = div_lat_q;
        strobe_d    = 1'b0;
        div_eff     = (step_div < DIV_W'(3)) ? DIV_W'(3) : step_div;

        if (stop) begin
            state_d = S_IDLE;
            addr_d  = '0;
            note_d  = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (play && !pause) begin
                        start_lat_d = loop_start;
                        end_lat_d   = loop_end;
                        div_lat_d   = div_eff;
                        addr_d      = loop_start;
                        state_d     = S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (pause) pend_d = 1'b1;
                    state_d = S_LATCH;
                end
                S_LATCH: begin
                    note_d   = rom_note[5:0];
                    cnt_d    = div_lat_q - DIV_W'(3);
                    strobe_d = 1'b1;
                    if (pend_q || pause) begin
                        state_d = S_PAUSED;
                        pend_d  = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (cnt_q == '0) begin
                        // A pause landing on the last HOLD cycle is deferred
                        // to the next LATCH so the step length stays exact.
                        if (addr_q == end_lat_q) begin
                            if (loop_en) begin
                                addr_d  = start_lat_q;
                                state_d = S_FETCH;
                                if (pause) pend_d = 1'b1;
                            end else begin
                                note_d  = '0;
                                state_d = S_DONE;
                            end
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_FETCH;
                            if (pause) pend_d = 1'b1;
                        end
                    end else begin
                        // The pausing cycle still counts as a HOLD cycle.
                        cnt_d = cnt_q - DIV_W'(1);
                        if (pause) state_d = S_PAUSED;
                    end
                end
                S_PAUSED: begin
                    if (play && !pause) state_d = S_HOLD;
                end
                default: state_d = S_IDLE;
            endcase
        end

        playing_d = (state_d == S_FETCH) || (state_d == S_LATCH) || (state_d == S_HOLD);
        paused_d  = (state_d == S_PAUSED);
        done_d    = (state_d == S_DONE);
        note_on_d = playing_d && (note_d != '0) &&
                    !(ARTIC_EN && (state_d == S_HOLD) && (cnt_d < DIV_W'(ARTIC_GAP)));
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            note_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            start_lat_q <= '0;
            end_lat_q   <= '0;
            div_lat_q   <= '0;
            strobe_q    <= 1'b0;
            note_on_q   <= 1'b0;
            playing_q   <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            note_q      <= note_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            start_lat_q <= start_lat_d;
            end_lat_q   <= end_lat_d;
            div_lat_q   <= div_lat_d;
            strobe_q    <= strobe_d;
            note_on_q   <= note_on_d;
            playing_q   <= playing_d;
            paused_q    <= paused_d;
            done_q      <= done_d;
        end
    end

    assign rom_addr    = addr_q;
    assign note_out    = note_q;
    assign note_on     = note_on_q;
    assign step_strobe = strobe_q;
    assign playing     = playing_q;
    assign paused      = paused_q;
    assign done        = done_q;

endmodule

// File: tb/tb_music_sequencer.sv
// Testbench for music_sequencer: directed stimulus pushes expected steps into
// a queue; a monitor pops and compares on every step_strobe.
module tb_music_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        play, pause, stop, loop_en;
    logic [7:0]  loop_start, loop_end;
    logic [23:0] step_div;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_note;
    logic [5:0]  note_out;
    logic        note_on, step_strobe, playing, paused, done;

    logic [7:0]  rom [256];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_strobe = 0;

    typedef struct {
        int addr;
        int note;
        int on;
        int period;
    } exp_t;
    exp_t exp_q[$];

    music_sequencer #(.ADDR_W(8), .DIV_W(24), .ARTIC_GAP(16)) dut (
        .clk(clk), .rst(rst), .play(play), .pause(pause), .stop(stop),
        .loop_en(loop_en), .loop_start(loop_start), .loop_end(loop_end),
        .step_div(step_div), .rom_addr(rom_addr), .rom_note(rom_note),
        .note_out(note_out), .note_on(note_on), .step_strobe(step_strobe),
        .playing(playing), .paused(paused), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk) begin
        rom_note <= rom[rom_addr];
        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int a, input int n, input int o, input int p);
        exp_t e;
        e.addr = a; e.note = n; e.on = o; e.period = p;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_play();
        play = 1'b1; step(); play = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; step(); stop = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_playing"}, playing, 0);
        chk({tag, "_paused"}, paused, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_note_out"}, note_out, 0);
        chk({tag, "_note_on"}, note_on, 0);
        chk({tag, "_strobe"}, step_strobe, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
    endtask

    // Scoreboard monitor: one expected entry per step_strobe.
    always @(negedge clk) begin
        if (!rst && step_strobe) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strobe_unexpected: got strobe at addr %0d note %0d expected none", rom_addr, note_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("step_addr", rom_addr, e.addr);
                chk("step_note", note_out, e.note);
                chk("step_gate", note_on, e.on);
                if (e.period != 0) chk("step_period", cyc - last_strobe, e.period);
            end
            last_strobe = cyc;
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        rom[0] = 8'd55; rom[1] = 8'hF7; rom[2] = 8'd55; rom[3] = 8'd0;
        rom[92] = 8'd58; rom[93] = 8'd58; rom[94] = 8'd58; rom[95] = 8'd0;
        rom[254] = 8'h45; rom[255] = 8'h06;

        rst = 1'b1; play = 0; pause = 0; stop = 0; loop_en = 0;
        loop_start = 0; loop_end = 3; step_div = 24'd8;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk_idle("reset");

        // Overworld theme, single pass, div 8.
        step();
        push(0, 55, 1, 0); push(1, 55, 1, 8); push(2, 55, 1, 8); push(3, 0, 0, 8);
        pulse_play();
        @(negedge clk);
        chk("t1_addr_t+1", rom_addr, 0);
        chk("t1_playing_t+1", playing, 1);
        wait_neg(2);
        chk("t1_strobe_t+3", step_strobe, 1);
        chk("t1_note_t+3", note_out, 55);
        chk("t1_gate_t+3", note_on, 1);
        wait_neg(32);
        chk("t1_done_t+35", done, 1);
        chk("t1_playing_t+35", playing, 0);
        chk("t1_note_t+35", note_out, 0);
        chk("t1_gate_t+35", note_on, 0);

        // Looping window 92..95, then stop+pause+play together mid-HOLD.
        loop_start = 92; loop_end = 95; loop_en = 1; step_div = 24'd8;
        step();
        for (int k = 0; k < 9; k++)
            push(92 + (k % 4), (k % 4 == 3) ? 0 : 58, (k % 4 == 3) ? 0 : 1, (k == 0) ? 0 : 8);
        pulse_play();
        @(negedge clk);
        wait_neg(66);
        chk("t2_done_never", done, 0);
        chk("t2_playing", playing, 1);
        step();
        stop = 1; pause = 1; play = 1;
        step();
        stop = 0; pause = 0; play = 0;
        @(negedge clk);
        chk_idle("t4a");

        // Pause four cycles into HOLD, twenty cycles paused, div 10.
        step_div = 24'd10;
        step();
        push(92, 58, 1, 0); push(93, 58, 1, 30); push(94, 58, 1, 10); push(95, 0, 0, 10);
        pulse_play();
        @(negedge clk);
        wait_neg(2);
        repeat (3) step();
        pause = 1; step(); pause = 0;
        @(negedge clk);
        chk("t3_paused", paused, 1);
        chk("t3_playing", playing, 0);
        chk("t3_gate", note_on, 0);
        chk("t3_note", note_out, 58);
        repeat (9) step();
        @(negedge clk);
        chk("t3_paused_mid", paused, 1);
        chk("t3_note_mid", note_out, 58);
        chk("t3_gate_mid", note_on, 0);
        repeat (10) step();
        pulse_play();
        @(negedge clk);
        wait_neg(27);
        pulse_stop();

        // Pause during FETCH: PAUSED straight after LATCH with new note.
        loop_start = 0; loop_end = 3; loop_en = 0; step_div = 24'd8;
        step();
        push(0, 55, 0, 0); push(1, 55, 1, 12);
        pulse_play();
        pause = 1; step(); pause = 0;
        @(negedge clk);
        step();
        @(negedge clk);
        chk("t4b_paused", paused, 1);
        chk("t4b_note", note_out, 55);
        chk("t4b_gate", note_on, 0);
        chk("t4b_strobe", step_strobe, 1);
        repeat (3) step();
        pulse_play();
        repeat (10) step();
        pulse_stop();
        @(negedge clk);
        chk("t4b_stopped", playing, 0);

        // step_div below 3 behaves as 3.
        step_div = 24'd1;
        step();
        push(0, 55, 1, 0); push(1, 55, 1, 3); push(2, 55, 1, 3); push(3, 0, 0, 3);
        pulse_play();
        wait_neg(20);
        chk("t5a_done", done, 1);

        // Window that wraps through the top of the address space.
        loop_start = 254; loop_end = 1; step_div = 24'd4;
        step();
        push(254, 5, 1, 0); push(255, 6, 1, 4); push(0, 55, 1, 4); push(1, 55, 1, 4);
        pulse_play();
        wait_neg(25);
        chk("t5b_done", done, 1);
        chk("t5b_note", note_out, 0);

        // Reset mid-HOLD, then a fresh start at div 4.
        loop_start = 0; loop_end = 3; step_div = 24'd8;
        step();
        push(0, 55, 1, 0);
        pulse_play();
        repeat (4) step();
        rst = 1; step(); rst = 0;
        @(negedge clk);
        chk_idle("t6_rst");
        step_div = 24'd4;
        step();
        push(0, 55, 1, 0);
        pulse_play();
        @(negedge clk);
        wait_neg(2);
        chk("t6_strobe_t+3", step_strobe, 1);
        chk("t6_note_t+3", note_out, 55);
        step();
        pulse_stop();
        wait_neg(5);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
